// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: priming states and
// Gray-code neighbour functions for the 2-bit {A,B} phase pair.
package quad_pkg;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [0:0] {PRIME, TRACK} quad_state_t;

    // Forward sequence on {A,B}: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] gray_next(input logic [1:0] p);
        logic [1:0] n;
        unique case (p)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] gray_prev(input logic [1:0] p);
        logic [1:0] n;
        unique case (p)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for one asynchronous bit; all stages
// clear to 0 on reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din};
        end
    end

    assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Incremental quadrature decoder: synchronizes A/B/index, decodes Gray steps
// and maintains a modulo-2^N position with clear/load/index priority.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned N           = 16,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         idx_in,
    input  logic         idx_en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         err_clr,
    output logic [N-1:0] pos,
    output logic         step,
    output logic         dir,
    output logic         err
);

    localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

    logic sa, sb, sidx;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk  (clk),
        .rst  (rst),
        .din  (a_in),
        .dout (sa)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk  (clk),
        .rst  (rst),
        .din  (b_in),
        .dout (sb)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_idx (
        .clk  (clk),
        .rst  (rst),
        .din  (idx_in),
        .dout (sidx)
    );

    quad_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]    prev_q, cur;
    logic          sidx_q;
    logic [N-1:0]  pos_q, pos_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic          err_q, err_d;
    logic          tracking, up, down, illegal, idx_rise;

    always_comb begin
        cur      = {sa, sb};
        tracking = (state_q == TRACK);
        up       = tracking && (cur == gray_next(prev_q));
        down     = tracking && (cur == gray_prev(prev_q));
        illegal  = tracking && (cur != prev_q) && (cur != gray_next(prev_q))
                   && (cur != gray_prev(prev_q));
        // Index edge is ignored while priming so a held index cannot fire spuriously
        idx_rise = tracking && idx_en && sidx && !sidx_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        // PRIME spans SYNC_STAGES+1 edges so prev captures a fully synchronized phase
        if (state_q == PRIME) begin
            if (cnt_q == '0) begin
                state_d = TRACK;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        step_d = up || down;
        dir_d  = up ? 1'b1 : (down ? 1'b0 : dir_q);

        if (clr) begin
            pos_d = '0;
        end else if (load) begin
            pos_d = d;
        end else if (idx_rise) begin
            pos_d = '0;
        end else if (up) begin
            pos_d = pos_q + N'(1);
        end else if (down) begin
            pos_d = pos_q - N'(1);
        end else begin
            pos_d = pos_q;
        end

        if (illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRIME;
            cnt_q   <= CntW'(SYNC_STAGES);
            prev_q  <= 2'b00;
            sidx_q  <= 1'b0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= cur;
            sidx_q  <= sidx;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign pos  = pos_q;
    assign step = step_q;
    assign dir  = dir_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: expected {pos,step,dir,err} tuples are queued
// as stimulus is applied and popped when the outputs are sampled.
module tb_quad_decoder;

    logic        clk, rst;
    logic        a_in, b_in, idx_in, idx_en, clr, load, err_clr;
    logic [15:0] d;
    logic [15:0] pos;
    logic        step, dir, err;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [18:0] sb_q[$];

    logic [15:0] m_pos;
    logic        m_dir, m_err;

    quad_decoder #(.N(16), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (a_in),
        .b_in    (b_in),
        .idx_in  (idx_in),
        .idx_en  (idx_en),
        .clr     (clr),
        .load    (load),
        .d       (d),
        .err_clr (err_clr),
        .pos     (pos),
        .step    (step),
        .dir     (dir),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] p, input logic s, input logic dr, input logic e);
        sb_q.push_back({p, s, dr, e});
    endtask

    task automatic check(input string tag);
        logic [18:0] exp_v, obs_v;
        checks++;
        obs_v = {pos, step, dir, err};
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed pos=%h step=%b dir=%b err=%b",
                   tag, pos, step, dir, err);
        end else begin
            exp_v = sb_q.pop_front();
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s: observed pos=%h step=%b dir=%b err=%b, expected pos=%h step=%b dir=%b err=%b",
                       tag, obs_v[18:3], obs_v[2], obs_v[1], obs_v[0],
                       exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    // Drive a new phase pair and check: nothing yet after 2 edges, result on the
    // 3rd edge, step gone on the 4th.
    task automatic phase(input string tag, input logic na, input logic nb,
                         input logic [15:0] npos, input logic ndir,
                         input logic nstep, input logic nerr);
        a_in = na;
        b_in = nb;
        push(m_pos, 1'b0, m_dir, m_err);
        push(npos, nstep, ndir, nerr);
        push(npos, 1'b0, ndir, nerr);
        tick(2);
        check({tag, "_pre"});
        tick(1);
        check(tag);
        tick(1);
        check({tag, "_post"});
        m_pos = npos;
        m_dir = ndir;
        m_err = nerr;
        tick(2);
    endtask

    initial begin
        rst = 1'b1; a_in = 1'b1; b_in = 1'b1; idx_in = 1'b0; idx_en = 1'b0;
        clr = 1'b0; load = 1'b0; err_clr = 1'b0; d = '0;
        m_pos = '0; m_dir = 1'b0; m_err = 1'b0;

        // Inputs held at 11 through reset must not count or flag
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        tick(3);
        check("reset_state");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(16'h0000, 1'b0, 1'b0, 1'b0);
            tick(1);
            check("prime_static11");
        end

        rst = 1'b1; a_in = 1'b0; b_in = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(5);

        phase("up1", 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
        phase("up2", 1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0);
        phase("up3", 1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0);
        phase("up4", 1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b0);

        d = 16'h0001; load = 1'b1;
        push(16'h0001, 1'b0, 1'b1, 1'b0);
        tick(1);
        load = 1'b0;
        check("load1");
        m_pos = 16'h0001;

        phase("down1", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        phase("down_wrap", 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        phase("illegal", 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // err_clr coincides with the edge that detects a second illegal jump
        a_in = 1'b1; b_in = 1'b1;
        push(16'hFFFF, 1'b0, 1'b0, 1'b1);
        push(16'hFFFF, 1'b0, 1'b0, 1'b1);
        tick(2);
        check("illegal2_pre");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_set_wins");
        tick(3);

        err_clr = 1'b1;
        push(16'hFFFF, 1'b0, 1'b0, 1'b0);
        tick(1);
        err_clr = 1'b0;
        check("err_clr");
        m_err = 1'b0;

        idx_en = 1'b1; d = 16'h0123; load = 1'b1;
        push(16'h0123, 1'b0, 1'b0, 1'b0);
        tick(1);
        load = 1'b0;
        check("load_0123");

        idx_in = 1'b1;
        push(16'h0123, 1'b0, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        tick(2);
        check("idx_pre");
        tick(1);
        check("idx_clear");
        m_pos = 16'h0000;
        // idx_in still high: index must not clear again
        phase("idx_once", 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0);
        idx_in = 1'b0;
        tick(3);

        idx_in = 1'b1;
        tick(2);
        d = 16'h0055; load = 1'b1;
        push(16'h0055, 1'b0, 1'b1, 1'b0);
        push(16'h0055, 1'b0, 1'b1, 1'b0);
        tick(1);
        load = 1'b0;
        check("load_beats_idx");
        tick(1);
        check("idx_no_refire");
        idx_in = 1'b0;
        tick(3);

        clr = 1'b1; load = 1'b1; d = 16'h0077;
        push(16'h0000, 1'b0, 1'b1, 1'b0);
        tick(1);
        clr = 1'b0; load = 1'b0;
        check("clr_beats_load");

        d = 16'hFFFF; load = 1'b1;
        push(16'hFFFF, 1'b0, 1'b1, 1'b0);
        tick(1);
        load = 1'b0;
        check("load_ffff");
        m_pos = 16'hFFFF;
        phase("up_wrap", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        d = 16'h0AAA; load = 1'b1;
        push(16'h0AAA, 1'b0, 1'b1, 1'b0);
        tick(1);
        load = 1'b0;
        check("load_0aaa");

        // Reset lands while a step is in flight through the synchronizers
        a_in = 1'b0; b_in = 1'b1;
        tick(1);
        #2 rst = 1'b1;
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        #1 check("rst_async");
        tick(2);
        rst = 1'b0;
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        tick(6);
        check("post_rst_idle");
        m_pos = 16'h0000; m_dir = 1'b0; m_err = 1'b0;
        phase("post_rst_step", 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
